// File: rtl/hbridge_driver.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_driver
//  Purpose  : Output stage for a dual H-bridge. For each motor it takes a
//             commanded direction and duty and produces the bridge direction
//             pins and the enable PWM. It inserts dead time on every direction
//             reversal, latches the duty at period start, and latches an
//             over-current fault from the current-sense comparators.
//  Ports    : clock, reset (async, active-high), enable,
//             dirA/dirB (1 = forward), dutyA/dutyB (high cycles per period),
//             senseA/senseB (async over-current), clearFault (pulse)
//             -> input1..input4 (bridge pins), PWMenA/PWMenB, faultA/faultB,
//                periodStart (one-cycle pulse per PWM period)
//  Revision : 1.0 - initial release
// ============================================================================
module hbridge_driver #(
   parameter int PERIOD   = 1666667,
   parameter int CW       = 21,
   parameter int DEADTIME = 100000,
   parameter int OC_LIMIT = 10000000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          dirA,
   input  logic          dirB,
   input  logic [CW-1:0] dutyA,
   input  logic [CW-1:0] dutyB,
   input  logic          senseA,
   input  logic          senseB,
   input  logic          clearFault,
   output logic          input1,
   output logic          input2,
   output logic          input3,
   output logic          input4,
   output logic          PWMenA,
   output logic          PWMenB,
   output logic          faultA,
   output logic          faultB,
   output logic          periodStart
);

   localparam int DW = $clog2(DEADTIME + 1);
   localparam int OW = $clog2(OC_LIMIT + 1);
   localparam logic [CW-1:0] C_CNT_LAST  = CW'(PERIOD - 1);
   localparam logic [DW-1:0] C_DEAD_LOAD = DW'(DEADTIME - 1);
   localparam logic [OW-1:0] C_OC_LAST   = OW'(OC_LIMIT - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_DRIVE = 2'd1,
      S_DEAD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Shared period counter
   // ---------------------------------------------------------------------
   logic [CW-1:0] cnt_q, cnt_d;
   logic          period_start_q, period_start_d;
   logic          cnt_zero;

   always_comb begin
      cnt_zero       = (cnt_q == '0);
      cnt_d          = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + CW'(1);
      period_start_d = cnt_zero;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         period_start_q <= period_start_d;
      end
   end

   // Per-motor views of the inputs so both channels share one description
   logic [1:0]    dir_v, sense_v;
   logic [CW-1:0] duty_v [2];
   logic [1:0]    pin_fwd, pin_rev, pwm_en, fault_v;

   assign dir_v     = {dirB, dirA};
   assign sense_v   = {senseB, senseA};
   assign duty_v[0] = dutyA;
   assign duty_v[1] = dutyB;

   // ---------------------------------------------------------------------
   // Motor channels
   // ---------------------------------------------------------------------
   for (genvar m = 0; m < 2; m++) begin : g_motor
      state_t        state_q, state_d;
      logic          applied_q, applied_d;
      logic [CW-1:0] duty_l_q, duty_l_d;
      logic [DW-1:0] dead_q, dead_d;
      logic [OW-1:0] oc_q, oc_d;
      logic          sync1_q, sync2_q;
      logic          fwd_q, fwd_d, rev_q, rev_d, pwm_q, pwm_d, fault_q, fault_d;

      always_comb begin
         // The compare at counter 0 already uses the newly sampled duty so
         // the first high cycle of a period lines up with periodStart.
         duty_l_d  = cnt_zero ? duty_v[m] : duty_l_q;
         state_d   = state_q;
         applied_d = applied_q;
         dead_d    = dead_q;
         oc_d      = '0;

         case (state_q)
            S_OFF: begin
               if (enable) begin
                  state_d   = S_DRIVE;
                  applied_d = dir_v[m];
               end
            end
            S_DRIVE: begin
               if (sync2_q && (oc_q != C_OC_LAST)) begin
                  oc_d = oc_q + OW'(1);
               end
               if (sync2_q && (oc_q == C_OC_LAST)) begin
                  state_d = S_FAULT;
               end else if (!enable) begin
                  state_d = S_OFF;
               end else if (dir_v[m] != applied_q) begin
                  state_d = S_DEAD;
                  dead_d  = C_DEAD_LOAD;
               end
            end
            S_DEAD: begin
               if (!enable) begin
                  state_d = S_OFF;
               end else if (dead_q == '0) begin
                  // Direction is re-sampled only here, so toggles during the
                  // dead time never restart it.
                  state_d   = S_DRIVE;
                  applied_d = dir_v[m];
               end else begin
                  dead_d = dead_q - DW'(1);
               end
            end
            S_FAULT: begin
               if (clearFault && !sync2_q) begin
                  state_d = S_OFF;
               end
            end
            default: state_d = S_OFF;
         endcase

         // Outputs come from the current state, so pins and PWM drop together
         // and the off cycles equal the cycles spent in DEAD.
         fwd_d   = (state_q == S_DRIVE) && applied_q;
         rev_d   = (state_q == S_DRIVE) && !applied_q;
         pwm_d   = (state_q == S_DRIVE) && (cnt_q < duty_l_d);
         fault_d = (state_q == S_FAULT);
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state_q   <= S_OFF;
            applied_q <= 1'b1;
            duty_l_q  <= '0;
            dead_q    <= '0;
            oc_q      <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            fwd_q     <= 1'b0;
            rev_q     <= 1'b0;
            pwm_q     <= 1'b0;
            fault_q   <= 1'b0;
         end else begin
            state_q   <= state_d;
            applied_q <= applied_d;
            duty_l_q  <= duty_l_d;
            dead_q    <= dead_d;
            oc_q      <= oc_d;
            sync1_q   <= sense_v[m];
            sync2_q   <= sync1_q;
            fwd_q     <= fwd_d;
            rev_q     <= rev_d;
            pwm_q     <= pwm_d;
            fault_q   <= fault_d;
         end
      end

      assign pin_fwd[m] = fwd_q;
      assign pin_rev[m] = rev_q;
      assign pwm_en[m]  = pwm_q;
      assign fault_v[m] = fault_q;
   end

   // Motor B is wired mirrored on the bridge: forward drives input4.
   assign input1      = pin_fwd[0];
   assign input2      = pin_rev[0];
   assign input3      = pin_rev[1];
   assign input4      = pin_fwd[1];
   assign PWMenA      = pwm_en[0];
   assign PWMenB      = pwm_en[1];
   assign faultA      = fault_v[0];
   assign faultB      = fault_v[1];
   assign periodStart = period_start_q;

endmodule
`default_nettype wire
